// File: rtl/byte_mem_responder_if.sv
// Request/response bus between the control unit (master) and the byte memory responder (slave).
interface byte_mem_responder_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_last;
  logic [7:0]        rsp_rdata;
  logic [31:0]       rsp_word;
  logic              busy;

  modport master (
    output req_valid, req_write, req_burst, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_last, rsp_rdata, rsp_word, busy
  );

  modport slave (
    input  req_valid, req_write, req_burst, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_last, rsp_rdata, rsp_word, busy
  );
endinterface

// File: rtl/byte_mem_responder.sv
// Byte-wide memory responder: single-byte load/store and 4-byte LSB-first fetch bursts,
// with programmable wait states between acceptance and the first access.
module byte_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                 clock,
  input logic                 reset,
  byte_mem_responder_if.slave bus
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StBeat = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              burst_q;
  logic [7:0]        wdata_q;

  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic [7:0]        rsp_rdata_q;
  logic [31:0]       rsp_word_q;

  logic [7:0]        mem [DEPTH];
  logic [IdxW-1:0]   mem_idx;
  logic [7:0]        rd_byte;
  logic              accept;
  logic              in_beat;
  logic              final_beat;

  assign accept     = bus.req_valid && (state_q == StIdle);
  assign in_beat    = (state_q == StBeat);
  assign final_beat = write_q || !burst_q || (beat_q == 2'd3);
  // Burst beats wrap modulo DEPTH through the truncated index
  assign mem_idx    = addr_q[IdxW-1:0] + IdxW'(beat_q);
  assign rd_byte    = mem[mem_idx];

  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_word  = rsp_word_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          beat_d = 2'd0;
          wait_d = WaitInit;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
          end else begin
            state_d = StBeat;
          end
        end
      end
      StWait: begin
        if (wait_q == 4'd0) begin
          state_d = StBeat;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StBeat: begin
        if (final_beat) begin
          state_d = StIdle;
          beat_d  = 2'd0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

  // Request fields are only sampled at acceptance; later input changes are ignored
  always_ff @(posedge clock) begin
    if (accept && !reset) begin
      addr_q  <= bus.req_addr;
      write_q <= bus.req_write;
      burst_q <= bus.req_burst && !bus.req_write;
      wdata_q <= bus.req_wdata;
    end
  end

  // Memory is never cleared; reset blocks a store on the same edge
  always_ff @(posedge clock) begin
    if (!reset && in_beat && write_q) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_word_q  <= 32'h0;
    end else begin
      rsp_valid_q <= in_beat;
      rsp_last_q  <= in_beat && final_beat;
      if (accept && bus.req_burst && !bus.req_write) begin
        rsp_word_q <= 32'h0;
      end
      if (in_beat && !write_q) begin
        rsp_rdata_q <= rd_byte;
        if (burst_q) begin
          rsp_word_q[8*beat_q +: 8] <= rd_byte;
        end else begin
          rsp_word_q <= {24'h0, rd_byte};
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_responder.sv
// Randomized self-checking bench for byte_mem_responder against a byte-array reference model.
module tb_byte_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_mem_responder_if #(.ADDR_W(8)) bus1 ();
  byte_mem_responder_if #(.ADDR_W(8)) bus0 ();

  byte_mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1)) u_dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1)
  );

  byte_mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (bus0)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  ref_mem  [256];
  logic [7:0]  ref0_mem [256];
  logic [7:0]  exp_rdata;
  logic [31:0] exp_word;
  logic [7:0]  exp0_rdata;

  // Request presented on bus1 while a transaction is in flight
  logic        nxt_valid, nxt_wr, nxt_burst;
  logic [7:0]  nxt_addr, nxt_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with DUT idle; returns at the negedge of the final response beat.
  task automatic txn(input logic wr, input logic burst, input logic [7:0] addr,
                     input logic [7:0] wdata);
    int nbeats;
    logic [7:0] b;
    nbeats          = (burst && !wr) ? 4 : 1;
    bus1.req_valid  = 1'b1;
    bus1.req_write  = wr;
    bus1.req_burst  = burst;
    bus1.req_addr   = addr;
    bus1.req_wdata  = wdata;
    check("ready_idle", bus1.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus1.req_valid  = nxt_valid;
    bus1.req_write  = nxt_wr;
    bus1.req_burst  = nxt_burst;
    bus1.req_addr   = nxt_addr;
    bus1.req_wdata  = nxt_wdata;
    if (wr) ref_mem[addr] = wdata;
    if (burst && !wr) exp_word = 32'h0;
    @(negedge clk);
    check("wait_state", {bus1.busy, bus1.req_ready, bus1.rsp_valid}, 3'b100);
    check("word_at_accept", bus1.rsp_word, exp_word);
    @(negedge clk);
    check("pre_beat", {bus1.busy, bus1.req_ready, bus1.rsp_valid}, 3'b100);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      b = ref_mem[8'(addr + 8'(k))];
      if (!wr) begin
        exp_rdata = b;
        if (burst) exp_word[8*k +: 8] = b;
        else       exp_word = {24'h0, b};
      end
      check("rsp_valid", bus1.rsp_valid, 1'b1);
      check("rsp_last", bus1.rsp_last, (k == nbeats - 1));
      check("rsp_rdata", bus1.rsp_rdata, exp_rdata);
      check("rsp_word", bus1.rsp_word, exp_word);
      check("ready_busy", {bus1.req_ready, bus1.busy}, (k == nbeats - 1) ? 2'b10 : 2'b01);
    end
  endtask

  // Zero-wait-state single transaction on bus0, same entry/exit convention as txn.
  task automatic txn0(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_burst = 1'b0;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    check("w0_ready", bus0.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = 8'($urandom);
    if (wr) ref0_mem[addr] = wdata;
    else    exp0_rdata = ref0_mem[addr];
    @(negedge clk);
    check("w0_beat", {bus0.busy, bus0.req_ready, bus0.rsp_valid}, 3'b100);
    @(negedge clk);
    check("w0_rsp", {bus0.rsp_valid, bus0.rsp_last, bus0.req_ready, bus0.busy}, 4'b1110);
    check("w0_rdata", bus0.rsp_rdata, exp0_rdata);
    if (!wr) check("w0_word", bus0.rsp_word, {24'h0, exp0_rdata});
  endtask

  initial begin
    nxt_valid = 1'b0; nxt_wr = 1'b0; nxt_burst = 1'b0; nxt_addr = 8'h0; nxt_wdata = 8'h0;
    exp_rdata = 8'h0; exp_word = 32'h0; exp0_rdata = 8'h0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_burst = 1'b0;
    bus1.req_addr  = 8'h0; bus1.req_wdata = 8'h0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_burst = 1'b0;
    bus0.req_addr  = 8'h0; bus0.req_wdata = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outs", {bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_last}, 4'b1000);
    check("reset_rdata", bus1.rsp_rdata, 8'h00);
    check("reset_word", bus1.rsp_word, 32'h0);
    check("reset_w0", {bus0.req_ready, bus0.busy, bus0.rsp_valid}, 3'b100);

    // Store then single read
    txn(1'b1, 1'b0, 8'h10, 8'hA5);
    txn(1'b0, 1'b0, 8'h10, 8'h00);
    check("t1_rdata", bus1.rsp_rdata, 8'hA5);
    check("t1_word", bus1.rsp_word, 32'h0000_00A5);

    // Burst fill order
    txn(1'b1, 1'b0, 8'h20, 8'h11);
    txn(1'b1, 1'b0, 8'h21, 8'h22);
    txn(1'b1, 1'b0, 8'h22, 8'h33);
    txn(1'b1, 1'b0, 8'h23, 8'h44);
    txn(1'b0, 1'b1, 8'h20, 8'h00);
    check("t2_word", bus1.rsp_word, 32'h4433_2211);

    // Burst wrapping past the top of memory
    txn(1'b1, 1'b0, 8'hFE, 8'hAA);
    txn(1'b1, 1'b0, 8'hFF, 8'hBB);
    txn(1'b1, 1'b0, 8'h00, 8'hCC);
    txn(1'b1, 1'b0, 8'h01, 8'hDD);
    txn(1'b0, 1'b1, 8'hFE, 8'h00);
    check("t3_word", bus1.rsp_word, 32'hDDCC_BBAA);

    // Store held pending during a burst, accepted on the rsp_last cycle
    txn(1'b1, 1'b0, 8'h30, 8'h99);
    nxt_valid = 1'b1; nxt_wr = 1'b1; nxt_burst = 1'b0; nxt_addr = 8'h30; nxt_wdata = 8'h55;
    txn(1'b0, 1'b1, 8'h20, 8'h00);
    check("t4_word", bus1.rsp_word, 32'h4433_2211);
    nxt_valid = 1'b0;
    txn(1'b1, 1'b0, 8'h30, 8'h55);
    txn(1'b0, 1'b0, 8'h30, 8'h00);
    check("t4_rdata", bus1.rsp_rdata, 8'h55);

    // Reset in the middle of a burst
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_burst = 1'b1; bus1.req_addr = 8'h20;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_beat0", {bus1.rsp_valid, bus1.rsp_rdata}, {1'b1, 8'h11});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_flags", {bus1.rsp_valid, bus1.rsp_last, bus1.busy, bus1.req_ready}, 4'b0001);
    check("t5_word", bus1.rsp_word, 32'h0);
    check("t5_rdata", bus1.rsp_rdata, 8'h00);
    exp_rdata = 8'h00;
    exp_word  = 32'h0;
    txn(1'b0, 1'b0, 8'h21, 8'h00);
    check("t5_read", bus1.rsp_rdata, 8'h22);

    // Fill the whole memory, then random traffic with garbage on the idle request lines
    for (int a = 0; a < 256; a++) txn(1'b1, 1'b0, 8'(a), 8'($urandom));
    for (int i = 0; i < 200; i++) begin
      nxt_wr    = 1'($urandom);
      nxt_burst = 1'($urandom);
      nxt_addr  = 8'($urandom);
      nxt_wdata = 8'($urandom);
      txn(($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check("idle_no_rsp", {bus1.rsp_valid, bus1.busy}, 2'b00);
        check("idle_hold", bus1.rsp_word, exp_word);
      end
    end

    // Zero wait states, including a back-to-back read
    txn0(1'b1, 8'h40, 8'h12);
    txn0(1'b1, 8'h41, 8'h34);
    txn0(1'b0, 8'h40, 8'h00);
    check("t6_rd0", bus0.rsp_rdata, 8'h12);
    txn0(1'b0, 8'h41, 8'h00);
    check("t6_rd1", bus0.rsp_word, 32'h0000_0034);
    @(negedge clk);
    check("t6_idle", bus0.rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
